// File: rtl/sap2_loader_pkg.sv
// sap2_loader_pkg: shared state encoding and framing constants for the SAP-2 UART loader
package sap2_loader_pkg;
    localparam int UART_BITS = 8;
    localparam int MAX_LEN = 256;
    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, OK, FAIL} state_t;
endpackage

// File: rtl/sap2_uart_rx.sv
// sap2_uart_rx: 8N1 receiver with 2-FF synchroniser, start re-check and stop-bit framing check
module sap2_uart_rx
    import sap2_loader_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);
    logic        s1_q, s2_q, prev_q, act_q, valid_q, ferr_q;
    logic [11:0] cnt_q, tgt_d;
    logic [3:0]  bit_q;
    logic [7:0]  sh_q;

    // bit 0 is the start bit, checked half a bit in; later bits are a full bit apart
    always_comb tgt_d = (bit_q == 4'd0) ? 12'(CLK_DIV / 2) : 12'(CLK_DIV);

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s1_q    <= rx;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (!act_q) begin
                if (prev_q && !s2_q) begin
                    act_q <= 1'b1;
                    cnt_q <= 12'd1;
                    bit_q <= '0;
                end
            end else if (cnt_q != tgt_d) begin
                cnt_q <= cnt_q + 12'd1;
            end else begin
                cnt_q <= 12'd1;
                bit_q <= bit_q + 4'd1;
                if (bit_q == 4'd0) act_q <= !s2_q;
                else if (bit_q < 4'(UART_BITS + 1)) sh_q <= {s2_q, sh_q[7:1]};
                else begin
                    act_q   <= 1'b0;
                    valid_q <= s2_q;
                    ferr_q  <= !s2_q;
                end
            end
        end
    end

    assign rx_valid = valid_q;
    assign rx_data  = sh_q;
    assign rx_ferr  = ferr_q;
endmodule

// File: rtl/sap2_uart_loader.sv
// sap2_uart_loader: receives LEN/DATA/CHK frames over UART and writes them into SAP-2 program memory
module sap2_uart_loader
    import sap2_loader_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int ADDR_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = (ADDR_W >= 8) ? MAX_LEN : (1 << ADDR_W);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q, mem_addr_q;
    logic [8:0]        cnt_q, len_d;
    logic [7:0]        sum_q, mem_wdata_q, rx_data;
    logic              rx_valid, rx_ferr, fail_d;
    logic              mem_we_q, cpu_hold_q, busy_q, done_q, err_q;

    sap2_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .CLK      (CLK),
        .RST      (RST),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    always_comb begin
        len_d  = (rx_data == 8'd0) ? 9'(MAX_LEN) : {1'b0, rx_data};
        len_d  = (len_d > 9'(DEPTH)) ? 9'(DEPTH) : len_d;
        fail_d = (state_q == LEN || state_q == DATA || state_q == CHK) &&
                 (rx_ferr || (state_q == CHK && rx_valid && rx_data != sum_q));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (fail_d) begin
                state_q <= FAIL;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE, FAIL: if (start) begin
                        state_q    <= LEN;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        addr_q     <= '0;
                        sum_q      <= '0;
                    end
                    LEN: if (rx_valid) begin
                        cnt_q   <= len_d;
                        state_q <= DATA;
                    end
                    DATA: if (rx_valid) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= rx_data;
                        sum_q       <= sum_q + rx_data;
                        addr_q      <= addr_q + ADDR_W'(1);
                        cnt_q       <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) state_q <= CHK;
                    end
                    CHK: if (rx_valid) begin
                        state_q    <= OK;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cpu_hold_q <= 1'b0;
                    end
                    OK:      state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sap2_uart_loader.sv
// tb_sap2_uart_loader: randomized frame stimulus with a write scoreboard and status checks
module tb_sap2_uart_loader;
    localparam int CLK_DIV = 4;
    localparam int ADDR_W  = 8;

    logic              CLK = 1'b0, RST = 1'b1, rx = 1'b1, start = 1'b0;
    logic              mem_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    int          checks = 0, failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got;
    logic [7:0]  f[$];

    sap2_uart_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx        (rx),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0h data=%0h, none expected", mem_addr, mem_wdata);
            end else begin
                got = exp_q.pop_front();
                if ({mem_addr, mem_wdata} != got) begin
                    failures++;
                    $display("FAIL write got addr=%0h data=%0h exp addr=%0h data=%0h",
                             mem_addr, mem_wdata, got[15:8], got[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CLK_DIV);
        end
        rx = stop;
        tick(CLK_DIV);
        rx = 1'b1;
        tick(2 * CLK_DIV);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Model: writes are data bytes at consecutive addresses up to a framing error; success needs no error and a matching sum.
    task automatic run_frame(input int ferr_idx, input bit glitch);
        int len, sum;
        bit good;
        len  = (f[0] == 8'd0) ? 256 : int'(f[0]);
        sum  = 0;
        good = (ferr_idx < 0);
        for (int i = 1; i <= len && i != ferr_idx; i++) begin
            exp_q.push_back({8'(i - 1), f[i]});
            sum += int'(f[i]);
        end
        good = good && ((sum % 256) == int'(f[len + 1]));
        pulse_start();
        tick(1);
        chk("busy_in_load", busy, 1);
        chk("hold_in_load", cpu_hold, 1);
        if (glitch) begin
            rx = 1'b0;
            tick(1);
            rx = 1'b1;
            tick(20);
        end
        foreach (f[i]) send_byte(f[i], i != ferr_idx);
        tick(4);
        chk("done", done, int'(good));
        chk("err", err, int'(!good));
        chk("cpu_hold", cpu_hold, int'(!good));
        chk("busy_after", busy, 0);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int len, sum, fe;
        tick(3);
        check_outputs_zero("reset");
        RST = 1'b0;
        tick(2);

        f = '{8'h03, 8'h3E, 8'h05, 8'h76, 8'hB9};
        run_frame(-1, 1'b0);

        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        tick(4);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 1);
        chk("idle_hold", cpu_hold, 0);

        f = '{8'h03, 8'h3E, 8'h05, 8'h76, 8'hB8};
        run_frame(-1, 1'b0);
        f = '{8'h02, 8'hA0, 8'h31, 8'hD1};
        run_frame(-1, 1'b0);

        f = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame(2, 1'b0);

        f = '{8'h02, 8'h7F, 8'h80, 8'hFF};
        run_frame(-1, 1'b1);

        pulse_start();
        exp_q.push_back({8'h00, 8'h10});
        exp_q.push_back({8'h01, 8'h20});
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        RST = 1'b1;
        tick(1);
        check_outputs_zero("mid_reset");
        RST = 1'b0;
        send_byte(8'h30, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h50, 1'b1);
        send_byte(8'hF0, 1'b1);
        tick(4);
        chk("mid_reset_pending", exp_q.size(), 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_done", done, 0);

        f = {};
        f.push_back(8'h00);
        for (int i = 0; i < 256; i++) f.push_back(8'(i));
        f.push_back(8'h80);
        run_frame(-1, 1'b0);

        repeat (8) begin
            len = int'($urandom_range(1, 12));
            sum = 0;
            f = {};
            f.push_back(8'(len));
            for (int i = 0; i < len; i++) begin
                f.push_back(8'($urandom_range(0, 255)));
                sum += int'(f[i + 1]);
            end
            f.push_back(8'(sum + (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0)));
            fe = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len + 1)) : -1;
            run_frame(fe, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
